// File: rtl/if_stage.sv
//==============================================================================
// Module   : if_stage
// Brief    : Instruction-fetch stage: PC register, imem addressing, IF/ID
//            register with stall, redirect (optional delay slot), flush, halt.
// Revision : 1.0
//==============================================================================
`default_nettype none

module if_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0800,
  parameter logic [15:0] HALT_INSTR = 16'h8000,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc_plus1,
  output logic        id_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        take;
  logic        bubble;
  logic        halt_hit;

  assign imem_addr = pc;
  assign pc_plus1  = pc + 16'd1;

  // A word is latched as valid on a normal fetch or in a kept delay slot;
  // flush always wins over either.
  assign take     = !flush && (redirect ? DELAY_SLOT : !stall);
  assign bubble   = flush || (redirect && !DELAY_SLOT);
  assign halt_hit = take && (imem_data == HALT_INSTR);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      id_instr    <= NOP_INSTR;
      id_pc_plus1 <= 16'h0000;
      id_valid    <= 1'b0;
      halted      <= 1'b0;
      state       <= ST_BOOT;
    end else begin
      case (state)
        ST_BOOT: begin
          id_instr <= NOP_INSTR;
          id_valid <= 1'b0;
          state    <= ST_RUN;
        end
        ST_RUN: begin
          if (halt_hit) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else if (redirect) begin
            pc <= redirect_pc;
          end else if (!stall) begin
            pc <= pc_plus1;
          end

          if (take) begin
            id_instr    <= imem_data;
            id_pc_plus1 <= pc_plus1;
            id_valid    <= 1'b1;
          end else if (bubble) begin
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
          end
        end
        ST_HALT: begin
          // The halt word itself was shown on entry; only bubbles follow.
          id_instr <= NOP_INSTR;
          id_valid <= 1'b0;
        end
        default: begin
          id_instr <= NOP_INSTR;
          id_valid <= 1'b0;
          state    <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
//==============================================================================
// Module   : tb_if_stage
// Brief    : Bench for if_stage; runs a delay-slot and a no-delay-slot copy
//            side by side against a behavioural model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_if_stage;

  localparam logic [15:0] NOP   = 16'h0800;
  localparam logic [15:0] HALTW = 16'h8000;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect;
  logic [15:0] redirect_pc;
  logic [15:0] mem [0:65535];

  // Index 0: DELAY_SLOT=1, index 1: DELAY_SLOT=0
  logic [15:0] d_addr [2];
  logic [15:0] d_data [2];
  logic [15:0] d_instr[2];
  logic [15:0] d_pp1  [2];
  logic        d_valid[2];
  logic        d_halted[2];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  assign d_data[0] = mem[d_addr[0]];
  assign d_data[1] = mem[d_addr[1]];

  if_stage #(.DELAY_SLOT(1'b1)) u_ds1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(d_addr[0]), .imem_data(d_data[0]),
    .id_instr(d_instr[0]), .id_pc_plus1(d_pp1[0]),
    .id_valid(d_valid[0]), .halted(d_halted[0])
  );

  if_stage #(.DELAY_SLOT(1'b0)) u_ds0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(d_addr[1]), .imem_data(d_data[1]),
    .id_instr(d_instr[1]), .id_pc_plus1(d_pp1[1]),
    .id_valid(d_valid[1]), .halted(d_halted[1])
  );

  // Behavioural model
  logic [15:0] m_pc[2], m_instr[2], m_pp1[2];
  logic        m_valid[2], m_halted[2], m_boot[2];
  logic [15:0] m_word;
  bit          m_ds, m_cap;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_ds = (k == 0);
      if (rst) begin
        m_pc[k] = 16'h0000; m_instr[k] = NOP; m_pp1[k] = 16'h0000;
        m_valid[k] = 1'b0; m_halted[k] = 1'b0; m_boot[k] = 1'b1;
      end else if (m_boot[k] || m_halted[k]) begin
        m_instr[k] = NOP; m_valid[k] = 1'b0; m_boot[k] = 1'b0;
      end else begin
        m_word = mem[m_pc[k]];
        m_cap  = 1'b0;
        if (flush || (redirect && !m_ds)) begin
          m_instr[k] = NOP; m_valid[k] = 1'b0;
        end else if (redirect || !stall) begin
          m_cap = 1'b1;
          m_instr[k] = m_word; m_pp1[k] = m_pc[k] + 16'd1; m_valid[k] = 1'b1;
        end
        if (m_cap && m_word == HALTW) m_halted[k] = 1'b1;
        else if (redirect)            m_pc[k] = redirect_pc;
        else if (!stall)              m_pc[k] = m_pc[k] + 16'd1;
      end
    end
  end

  task automatic chk(input int k, input string nm, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[ds%0d] t=%0t: got %h, expected %h", nm, (k == 0) ? 1 : 0, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk(k, "imem_addr", d_addr[k], m_pc[k]);
        chk(k, "id_instr", d_instr[k], m_instr[k]);
        chk(k, "id_valid", {15'd0, d_valid[k]}, {15'd0, m_valid[k]});
        chk(k, "halted", {15'd0, d_halted[k]}, {15'd0, m_halted[k]});
        if (m_valid[k]) chk(k, "id_pc_plus1", d_pp1[k], m_pp1[k]);
      end
    end
  end

  logic [15:0] save_instr, save_pp1;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i] == HALTW) mem[i] = 16'h1234;
    end
    mem[0] = 16'h6901;
    mem[1] = 16'h6A01;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;

    // Reset / boot
    @(negedge clk); chk_en = 1'b1;
    chk(0, "lit_rst_valid", {15'd0, d_valid[0]}, 16'd0);
    chk(1, "lit_rst_instr", d_instr[1], NOP);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk(0, "lit_boot_valid", {15'd0, d_valid[0]}, 16'd0);
    chk(0, "lit_boot_addr", d_addr[0], 16'h0000);
    @(negedge clk);
    chk(0, "lit_first_instr", d_instr[0], 16'h6901);
    chk(1, "lit_first_pp1", d_pp1[1], 16'h0001);
    @(negedge clk);
    chk(0, "lit_second_instr", d_instr[0], 16'h6A01);
    chk(0, "lit_second_addr", d_addr[0], 16'h0002);

    // Stall at pc=5
    repeat (3) @(negedge clk);
    chk(0, "lit_prestall_addr", d_addr[0], 16'h0005);
    save_instr = d_instr[0]; save_pp1 = d_pp1[0];
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk(0, "lit_stall_addr", d_addr[0], 16'h0005);
      chk(0, "lit_stall_instr", d_instr[0], save_instr);
      chk(0, "lit_stall_pp1", d_pp1[0], save_pp1);
    end
    stall = 1'b0;
    @(negedge clk);
    chk(0, "lit_resume_instr", d_instr[0], mem[5]);
    chk(0, "lit_resume_pp1", d_pp1[0], 16'h0006);

    // Redirect at pc=0x0A
    repeat (4) @(negedge clk);
    chk(0, "lit_preredir_addr", d_addr[0], 16'h000A);
    redirect = 1'b1; redirect_pc = 16'h0020;
    @(negedge clk);
    chk(0, "lit_redir_ds1_instr", d_instr[0], mem[16'h000A]);
    chk(0, "lit_redir_ds1_valid", {15'd0, d_valid[0]}, 16'd1);
    chk(1, "lit_redir_ds0_instr", d_instr[1], NOP);
    chk(1, "lit_redir_ds0_valid", {15'd0, d_valid[1]}, 16'd0);
    chk(1, "lit_redir_addr", d_addr[1], 16'h0020);
    stall = 1'b1; redirect_pc = 16'h0030;
    @(negedge clk);
    chk(0, "lit_redirstall_instr", d_instr[0], mem[16'h0020]);
    chk(0, "lit_redirstall_addr", d_addr[0], 16'h0030);
    chk(1, "lit_redirstall_addr", d_addr[1], 16'h0030);

    // Flush with stall, then flush with redirect
    redirect = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk(0, "lit_flushstall_valid", {15'd0, d_valid[0]}, 16'd0);
    chk(0, "lit_flushstall_instr", d_instr[0], NOP);
    chk(0, "lit_flushstall_addr", d_addr[0], 16'h0030);
    stall = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    chk(0, "lit_flushredir_valid", {15'd0, d_valid[0]}, 16'd0);
    chk(0, "lit_flushredir_addr", d_addr[0], 16'h0040);
    flush = 1'b0; redirect = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      rst         = ($urandom_range(0, 99) < 2);
      stall       = ($urandom_range(0, 99) < 25);
      flush       = ($urandom_range(0, 99) < 10);
      redirect    = ($urandom_range(0, 99) < 12);
      redirect_pc = 16'($urandom);
      @(negedge clk);
    end
    stall = 1'b0; flush = 1'b0; redirect = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Halt: ignored when stalled, flushed or squashed; taken otherwise
    mem[16'h002B] = HALTW;
    redirect = 1'b1; redirect_pc = 16'h002B;
    @(negedge clk); redirect = 1'b0;
    stall = 1'b1;
    @(negedge clk); stall = 1'b0;
    chk(0, "lit_halt_stall_halted", {15'd0, d_halted[0]}, 16'd0);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk(0, "lit_halt_flush_halted", {15'd0, d_halted[0]}, 16'd0);
    chk(0, "lit_halt_flush_addr", d_addr[0], 16'h002C);
    redirect = 1'b1; redirect_pc = 16'h002B;
    @(negedge clk);
    redirect_pc = 16'h0050;
    @(negedge clk);
    chk(0, "lit_halt_ds1_halted", {15'd0, d_halted[0]}, 16'd1);
    chk(0, "lit_halt_ds1_instr", d_instr[0], HALTW);
    chk(0, "lit_halt_ds1_addr", d_addr[0], 16'h002B);
    chk(1, "lit_halt_ds0_halted", {15'd0, d_halted[1]}, 16'd0);
    chk(1, "lit_halt_ds0_addr", d_addr[1], 16'h0050);
    redirect_pc = 16'h002B;
    @(negedge clk); redirect = 1'b0;
    chk(0, "lit_halt_ds1_bubble", d_instr[0], NOP);
    @(negedge clk);
    chk(1, "lit_halt_ds0_halted", {15'd0, d_halted[1]}, 16'd1);
    chk(1, "lit_halt_ds0_instr", d_instr[1], HALTW);
    chk(1, "lit_halt_ds0_pp1", d_pp1[1], 16'h002C);
    redirect = 1'b1; stall = 1'b1; flush = 1'b1; redirect_pc = 16'h0077;
    repeat (3) begin
      @(negedge clk);
      chk(0, "lit_halted_addr", d_addr[0], 16'h002B);
      chk(1, "lit_halted_addr", d_addr[1], 16'h002B);
    end
    redirect = 1'b0; stall = 1'b0; flush = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk(0, "lit_unhalt_addr", d_addr[0], 16'h0000);
    chk(1, "lit_unhalt_halted", {15'd0, d_halted[1]}, 16'd0);
    mem[16'h002B] = 16'h1111;

    // Wrap at 0xFFFF
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    @(negedge clk); redirect = 1'b0;
    chk(0, "lit_wrap_pre_addr", d_addr[0], 16'hFFFF);
    @(negedge clk);
    chk(0, "lit_wrap_pp1", d_pp1[0], 16'h0000);
    chk(1, "lit_wrap_pp1", d_pp1[1], 16'h0000);
    chk(0, "lit_wrap_addr", d_addr[0], 16'h0000);
    @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
